// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between the fetch and data ports.
// Data accesses win by default; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants with a fetch waiting.
// Optional one-entry fetch buffer is enabled by defining INST_BUF_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           inst_data,
  output logic                  inst_stall,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_dout,
  output logic [31:0]           mem_din,
  output logic                  mem_stall,
  output logic                  ram_req,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ack
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TAG_W  = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  ram_req_q, ram_req_d;
  logic                  ram_wen_q, ram_wen_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]     inst_data_q, inst_data_d;
  logic [DATA_W-1:0]     mem_din_q, mem_din_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

  logic data_req;
  logic fetch_req;
  logic starve_full;
  logic ack_i;
  logic ack_d;
  logic buf_hit;
  logic grant_d;
  logic grant_i;

`ifdef INST_BUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  // Buffer hit: fetch served from the buffer while the RAM is idle or busy with data
  assign buf_hit = buf_valid_q & inst_ren & (state_q != GNT_I)
                 & (buf_tag_q == inst_addr[ADDR_WIDTH-1:2]);
`else
  assign buf_hit = 1'b0;
`endif

  assign data_req    = mem_ren | mem_wen;
  assign fetch_req   = inst_ren & ~buf_hit;
  assign starve_full = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign ack_i       = ~rst & ram_ack & (state_q == GNT_I);
  assign ack_d       = ~rst & ram_ack & (state_q == GNT_D);

  // Stalls and read-data pass-through; both stalls forced low during reset
  assign inst_stall = ~rst & inst_ren & ~ack_i & ~buf_hit;
  assign mem_stall  = ~rst & data_req & ~ack_d;
  assign mem_din    = (ack_d & ~ram_wen_q) ? ram_rdata : mem_din_q;
`ifdef INST_BUF_EN
  assign inst_data  = ack_i ? ram_rdata : (buf_hit ? buf_data_q : inst_data_q);
`else
  assign inst_data  = ack_i ? ram_rdata : inst_data_q;
`endif

  assign ram_req   = ram_req_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // Next-state: arbitration, grant capture, ack completion, starvation count
  always_comb begin
    state_d      = state_q;
    ram_req_d    = ram_req_q;
    ram_wen_d    = ram_wen_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    inst_data_d  = inst_data_q;
    mem_din_d    = mem_din_q;
    starve_cnt_d = starve_cnt_q;
    grant_d      = 1'b0;
    grant_i      = 1'b0;
`ifdef INST_BUF_EN
    buf_valid_d  = buf_valid_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (data_req && !(fetch_req && starve_full)) begin
          grant_d = 1'b1;
        end else if (fetch_req) begin
          grant_i = 1'b1;
        end
      end
      GNT_D: begin
        if (ram_ack) begin
          state_d   = IDLE;
          ram_req_d = 1'b0;
          ram_wen_d = 1'b0;
          if (!ram_wen_q) begin
            mem_din_d = ram_rdata;
          end
        end
      end
      GNT_I: begin
        if (ram_ack) begin
          state_d     = IDLE;
          ram_req_d   = 1'b0;
          inst_data_d = ram_rdata;
`ifdef INST_BUF_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = ram_addr_q[ADDR_WIDTH-1:2];
          buf_data_d  = ram_rdata;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        ram_req_d = 1'b0;
      end
    endcase

    if (grant_d) begin
      state_d     = GNT_D;
      ram_req_d   = 1'b1;
      ram_wen_d   = mem_wen;
      ram_addr_d  = mem_addr;
      ram_wdata_d = mem_dout;
`ifdef INST_BUF_EN
      if (mem_wen && (mem_addr[ADDR_WIDTH-1:2] == buf_tag_q)) begin
        buf_valid_d = 1'b0;
      end
`endif
    end

    if (grant_i) begin
      state_d    = GNT_I;
      ram_req_d  = 1'b1;
      ram_wen_d  = 1'b0;
      ram_addr_d = inst_addr;
    end

    if (!inst_ren || grant_i || buf_hit) begin
      starve_cnt_d = '0;
    end else if (grant_d && !starve_full) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ram_req_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      inst_data_q  <= '0;
      mem_din_q    <= '0;
      starve_cnt_q <= '0;
`ifdef INST_BUF_EN
      buf_valid_q  <= 1'b0;
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ram_req_q    <= ram_req_d;
      ram_wen_q    <= ram_wen_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      inst_data_q  <= inst_data_d;
      mem_din_q    <= mem_din_d;
      starve_cnt_q <= starve_cnt_d;
`ifdef INST_BUF_EN
      buf_valid_q  <= buf_valid_d;
      buf_tag_q    <= buf_tag_d;
      buf_data_q   <= buf_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-programmable RAM model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_ren;
  logic [AW-1:0] inst_addr;
  logic [31:0]   inst_data;
  logic          inst_stall;
  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dout;
  logic [31:0]   mem_din;
  logic          mem_stall;
  logic          ram_req;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;
  logic          ram_ack;

  logic          model_ack = 1'b0;
  logic          force_ack;
  int unsigned   ram_lat;
  int unsigned   wait_cnt = 0;
  bit [31:0]     wmem   [256];
  bit            wvalid [256];

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   grant_cnt = 0;
  logic [31:0]   last_din;
  logic [64:0]   grant_q [$];
  logic [31:0]   inst_exp_q [$];
  logic [31:0]   din_exp_q [$];

  assign ram_ack = model_ack | force_ack;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_stall(inst_stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_stall(mem_stall),
    .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[9:2] == 8'd0) return 32'h2008000A;
    return {16'hC0DE, 8'h00, a[9:2]};
  endfunction

  function automatic logic [64:0] gnt(input logic wen, input logic [31:0] a, input logic [31:0] d);
    return {wen, a, d};
  endfunction

  // RAM model: acks ram_lat cycles after the request is first seen
  always @(posedge clk) begin
    model_ack <= 1'b0;
    if (ram_req && !model_ack) begin
      if (wait_cnt + 1 >= ram_lat) begin
        model_ack <= 1'b1;
        wait_cnt  <= 0;
        if (ram_wen) begin
          wmem[ram_addr[9:2]]   <= ram_wdata;
          wvalid[ram_addr[9:2]] <= 1'b1;
          ram_rdata             <= 32'hBAD0BAD0;
        end else begin
          ram_rdata <= wvalid[ram_addr[9:2]] ? wmem[ram_addr[9:2]] : init_word(ram_addr);
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else if (!ram_req) begin
      wait_cnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: grant order/contents on ram_req rise, read data on each completion
  task automatic monitor();
    logic        req_prev;
    logic [31:0] held_addr;
    logic [64:0] g;
    logic [31:0] e;
    req_prev  = 1'b0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev = 1'b0;
      end else begin
        if (ram_req && !req_prev) begin
          grant_cnt++;
          check_eq("grant_expected", 64'(grant_q.size() != 0), 64'd1);
          if (grant_q.size() != 0) begin
            g = grant_q.pop_front();
            check_eq("grant_wen", 64'(ram_wen), 64'(g[64]));
            check_eq("grant_addr", 64'(ram_addr), 64'(g[63:32]));
            if (g[64]) check_eq("grant_wdata", 64'(ram_wdata), 64'(g[31:0]));
          end
          held_addr = ram_addr;
        end else if (ram_req) begin
          check_eq("req_addr_stable", 64'(ram_addr), 64'(held_addr));
        end
        if (inst_ren && !inst_stall) begin
          check_eq("inst_done_expected", 64'(inst_exp_q.size() != 0), 64'd1);
          if (inst_exp_q.size() != 0) begin
            e = inst_exp_q.pop_front();
            check_eq("inst_data", 64'(inst_data), 64'(e));
          end
        end
        if ((mem_ren || mem_wen) && !mem_stall) begin
          check_eq("data_done_expected", 64'(din_exp_q.size() != 0), 64'd1);
          if (din_exp_q.size() != 0) begin
            e = din_exp_q.pop_front();
            check_eq("mem_din", 64'(mem_din), 64'(e));
          end
        end
        req_prev = ram_req;
      end
    end
  endtask

  // Core-like drivers: called at posedge+1, hold the request until the stall drops
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
    bit done;
    inst_ren  = 1'b1;
    inst_addr = a;
    inst_exp_q.push_back(exp);
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = !inst_stall;
    end
    check_eq("fetch_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    inst_ren = 1'b0;
  endtask

  task automatic data_op(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp);
    bit done;
    mem_ren  = ~wen;
    mem_wen  = wen;
    mem_addr = a;
    mem_dout = wd;
    din_exp_q.push_back(exp);
    last_din = exp;
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = !mem_stall;
    end
    check_eq("data_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    data_op(1'b0, a, 32'h0, init_word(a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned gc;
    rst = 1'b1; inst_ren = 1'b1; inst_addr = '0; mem_ren = 1'b1; mem_wen = 1'b0;
    mem_addr = '0; mem_dout = '0; force_ack = 1'b0; ram_lat = 1; last_din = '0;
    fork monitor(); join_none

    // Reset state, with both requests raised to show stalls stay low in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ram_req", 64'(ram_req), 64'd0);
    check_eq("rst_ram_wen", 64'(ram_wen), 64'd0);
    check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    check_eq("rst_inst_data", 64'(inst_data), 64'd0);
    check_eq("rst_mem_din", 64'(mem_din), 64'd0);
    check_eq("rst_inst_stall", 64'(inst_stall), 64'd0);
    check_eq("rst_mem_stall", 64'(mem_stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; inst_ren = 1'b0; mem_ren = 1'b0;

    // Fetch only: stall 1,1,0 with one-cycle RAM latency
    grant_q.push_back(gnt(1'b0, 32'h0, 32'h0));
    inst_exp_q.push_back(32'h2008000A);
    inst_ren = 1'b1; inst_addr = 32'h0;
    @(negedge clk); check_eq("t1_stall_c0", 64'(inst_stall), 64'd1);
    @(negedge clk); check_eq("t1_stall_c1", 64'(inst_stall), 64'd1);
    @(negedge clk); check_eq("t1_stall_c2", 64'(inst_stall), 64'd0);
    @(posedge clk); #1;
    inst_ren = 1'b0;

    // Same-cycle fetch and load: data wins
    grant_q.push_back(gnt(1'b0, 32'h100, 32'h0));
    grant_q.push_back(gnt(1'b0, 32'h4, 32'h0));
    fork
      fetch(32'h4, init_word(32'h4));
      load(32'h100);
    join

    // Starvation: four data grants, forced fetch, data resumes
    ram_lat = 2;
    for (int i = 0; i < 4; i++) grant_q.push_back(gnt(1'b0, 32'h200 + 32'(4 * i), 32'h0));
    grant_q.push_back(gnt(1'b0, 32'hC, 32'h0));
    grant_q.push_back(gnt(1'b0, 32'h210, 32'h0));
    grant_q.push_back(gnt(1'b0, 32'h214, 32'h0));
    fork
      fetch(32'hC, init_word(32'hC));
      begin
        for (int i = 0; i < 6; i++) load(32'h200 + 32'(4 * i));
      end
    join

    // Store leaves mem_din unchanged; read back through the RAM
    ram_lat = 1;
    grant_q.push_back(gnt(1'b1, 32'h20, 32'hDEADBEEF));
    data_op(1'b1, 32'h20, 32'hDEADBEEF, last_din);
    grant_q.push_back(gnt(1'b0, 32'h20, 32'h0));
    data_op(1'b0, 32'h20, 32'h0, 32'hDEADBEEF);

    // Load dropped mid-grant: no stall, result still registered
    ram_lat = 3;
    grant_q.push_back(gnt(1'b0, 32'h30, 32'h0));
    mem_ren = 1'b1; mem_addr = 32'h30;
    @(negedge clk);
    @(negedge clk); check_eq("flush_req", 64'(ram_req), 64'd1);
    @(posedge clk); #1;
    mem_ren = 1'b0;
    @(negedge clk); check_eq("flush_stall", 64'(mem_stall), 64'd0);
    repeat (4) @(negedge clk);
    check_eq("flush_din", 64'(mem_din), 64'(init_word(32'h30)));
    check_eq("flush_idle_req", 64'(ram_req), 64'd0);
    @(posedge clk); #1;

    // Reset while a data grant awaits ack, then a stale ack
    ram_lat = 4;
    grant_q.push_back(gnt(1'b0, 32'h40, 32'h0));
    mem_ren = 1'b1; mem_addr = 32'h40;
    @(negedge clk);
    @(negedge clk); check_eq("t5_req_before_rst", 64'(ram_req), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_mem_stall_rst", 64'(mem_stall), 64'd0);
    check_eq("t5_inst_stall_rst", 64'(inst_stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ren = 1'b0; last_din = '0;
    @(negedge clk); check_eq("t5_req_after_rst", 64'(ram_req), 64'd0);
    @(posedge clk); #1;
    force_ack = 1'b1;
    @(negedge clk); check_eq("t5_mem_din_stale", 64'(mem_din), 64'd0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    check_eq("t5_req_stale", 64'(ram_req), 64'd0);
    check_eq("t5_mem_din_after", 64'(mem_din), 64'd0);
    @(posedge clk); #1;
    ram_lat = 1;
    grant_q.push_back(gnt(1'b0, 32'h44, 32'h0));
    load(32'h44);

    // Repeated fetch, store to the same word, fetch again
    grant_q.push_back(gnt(1'b0, 32'h8, 32'h0));
    fetch(32'h8, init_word(32'h8));
    gc = grant_cnt;
`ifndef INST_BUF_EN
    grant_q.push_back(gnt(1'b0, 32'h8, 32'h0));
`endif
    fetch(32'h8, init_word(32'h8));
`ifdef INST_BUF_EN
    check_eq("t6_hit_no_ram", 64'(grant_cnt - gc), 64'd0);
`else
    check_eq("t6_second_ram", 64'(grant_cnt - gc), 64'd1);
`endif
    grant_q.push_back(gnt(1'b1, 32'h8, 32'h55AA1234));
    data_op(1'b1, 32'h8, 32'h55AA1234, last_din);
    gc = grant_cnt;
    grant_q.push_back(gnt(1'b0, 32'h8, 32'h0));
    fetch(32'h8, 32'h55AA1234);
    check_eq("t6_miss_after_store", 64'(grant_cnt - gc), 64'd1);

    repeat (3) @(negedge clk);
    check_eq("grant_q_empty", 64'(grant_q.size()), 64'd0);
    check_eq("inst_q_empty", 64'(inst_exp_q.size()), 64'd0);
    check_eq("din_q_empty", 64'(din_exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
